// File: rtl/enlynx_modport.sv
// ---------------------------------------------------------------------------
// enlynx_modport
//
// Two-channel 32-bit event counter with per-period snapshot.
// Each channel accumulates single-cycle event strobes while counting is
// enabled. An end-of-period strobe publishes the accumulated counts and the
// sticky overflow flags to stable output registers, then restarts
// accumulation from zero. The event sampled on the eop edge belongs to the
// period that is closing.
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   events_i      in   [1:0]    event strobes, one bit per channel
//   enable_cnt_i  in   1        counting enable (level)
//   eop_i         in   1        end-of-period strobe: snapshot and restart
//   counters_o    out  [1:0][31:0]  snapshot counts of the last period
//   overflow_o    out  [1:0]    snapshot overflow flags of the last period
//
// Configuration macro:
//   ENLYNX_SATURATE_EN  when defined, accumulators and snapshot counts
//                       saturate at 32'hFFFF_FFFF instead of wrapping.
//                       The overflow flag behaves the same either way.
// ---------------------------------------------------------------------------
module enlynx_modport (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       events_i,
  input  logic             enable_cnt_i,
  input  logic             eop_i,
  output logic [1:0][31:0] counters_o,
  output logic [1:0]       overflow_o
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Next accumulator value for one channel given its increment term.
  function automatic logic [31:0] acc_step(input logic [31:0] acc,
                                           input logic        inc);
`ifdef ENLYNX_SATURATE_EN
    if (inc && (acc != CNT_MAX)) begin
      return acc + 32'd1;
    end
    return acc;
`else
    return acc + {31'd0, inc};
`endif
  endfunction

  // Per-channel accumulators are kept as separate registers so each channel
  // can be observed or preloaded on its own.
  logic [31:0]       acc_ch0_q, acc_ch0_d;
  logic [31:0]       acc_ch1_q, acc_ch1_d;
  logic [1:0]        ovf_q, ovf_d;
  logic [1:0][31:0]  counters_q, counters_d;
  logic [1:0]        overflow_q, overflow_d;

  logic [1:0]        inc;
  logic [1:0]        at_max;
  logic [1:0]        ovf_hit;
  logic [31:0]       stepped_ch0;
  logic [31:0]       stepped_ch1;

  always_comb begin
    inc         = {2{enable_cnt_i}} & events_i;
    at_max      = {(acc_ch1_q == CNT_MAX), (acc_ch0_q == CNT_MAX)};
    // An increment attempted at max marks overflow in both wrap and
    // saturate builds.
    ovf_hit     = inc & at_max;
    stepped_ch0 = acc_step(acc_ch0_q, inc[0]);
    stepped_ch1 = acc_step(acc_ch1_q, inc[1]);

    acc_ch0_d   = stepped_ch0;
    acc_ch1_d   = stepped_ch1;
    ovf_d       = ovf_q | ovf_hit;
    counters_d  = counters_q;
    overflow_d  = overflow_q;

    if (eop_i) begin
      // The eop-cycle event is folded into the snapshot, and the new
      // period starts from zero, so no event is lost or counted twice.
      counters_d[0] = stepped_ch0;
      counters_d[1] = stepped_ch1;
      overflow_d    = ovf_q | ovf_hit;
      acc_ch0_d     = 32'd0;
      acc_ch1_d     = 32'd0;
      ovf_d         = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_ch0_q  <= 32'd0;
      acc_ch1_q  <= 32'd0;
      ovf_q      <= 2'b00;
      counters_q <= '0;
      overflow_q <= 2'b00;
    end else begin
      acc_ch0_q  <= acc_ch0_d;
      acc_ch1_q  <= acc_ch1_d;
      ovf_q      <= ovf_d;
      counters_q <= counters_d;
      overflow_q <= overflow_d;
    end
  end

  assign counters_o = counters_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_enlynx_modport.sv
// ---------------------------------------------------------------------------
// tb_enlynx_modport
//
// Directed testbench for enlynx_modport. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at that same point, away from the
// active edge. Expected values are hand-computed constants.
// Honours ENLYNX_SATURATE_EN for the overflow scenario.
// ---------------------------------------------------------------------------
module tb_enlynx_modport;

  logic             clk;
  logic             rst_n;
  logic [1:0]       events_i;
  logic             enable_cnt_i;
  logic             eop_i;
  logic [1:0][31:0] counters_o;
  logic [1:0]       overflow_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  enlynx_modport dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .events_i     (events_i),
    .enable_cnt_i (enable_cnt_i),
    .eop_i        (eop_i),
    .counters_o   (counters_o),
    .overflow_o   (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one cycle of inputs; returns 1 ns after the sampling edge.
  task automatic step(input logic [1:0] ev, input logic en, input logic eop);
    events_i     = ev;
    enable_cnt_i = en;
    eop_i        = eop;
    @(posedge clk);
    #1;
    events_i     = 2'b00;
    enable_cnt_i = 1'b0;
    eop_i        = 1'b0;
  endtask

  initial begin
    // Reset with random inputs: outputs clear without a clock edge.
    rst_n        = 1'b0;
    events_i     = 2'($urandom);
    enable_cnt_i = 1'($urandom);
    eop_i        = 1'($urandom);
    #3;
    check("rst_cnt0", counters_o[0], 32'd0);
    check("rst_cnt1", counters_o[1], 32'd0);
    check("rst_ovf", {30'd0, overflow_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    events_i     = 2'b00;
    enable_cnt_i = 1'b0;
    eop_i        = 1'b0;
    rst_n        = 1'b1;
    @(posedge clk);
    #1;
    step(2'b00, 1'b0, 1'b0);
    check("rst_hold_cnt0", counters_o[0], 32'd0);
    check("rst_hold_ovf", {30'd0, overflow_o}, 32'd0);

    // Basic count: 5 on ch0, 3 on ch1.
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1);
    check("basic_cnt0", counters_o[0], 32'd5);
    check("basic_cnt1", counters_o[1], 32'd3);
    check("basic_ovf", {30'd0, overflow_o}, 32'd0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    check("basic_hold_cnt0", counters_o[0], 32'd5);
    step(2'b00, 1'b1, 1'b1);
    check("empty_cnt0", counters_o[0], 32'd0);
    check("empty_cnt1", counters_o[1], 32'd0);

    // Enable gating: 4 counted, 6 ignored.
    for (int i = 0; i < 4; i++) step(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);
    check("gate_cnt0", counters_o[0], 32'd4);
    check("gate_cnt1", counters_o[1], 32'd0);

    // Boundary: event on the eop edge closes into this period.
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b1);
    check("bound_eop_cnt0", counters_o[0], 32'd3);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1);
    check("bound_next_cnt0", counters_o[0], 32'd1);

    // Overflow: preload ch0 accumulator to max-1, then 3 events.
    force dut.acc_ch0_q = 32'hFFFF_FFFE;
    step(2'b00, 1'b0, 1'b0);
    release dut.acc_ch0_q;
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1);
`ifdef ENLYNX_SATURATE_EN
    check("ovf_cnt0", counters_o[0], 32'hFFFF_FFFF);
`else
    check("ovf_cnt0", counters_o[0], 32'd1);
`endif
    check("ovf_flag0", {31'd0, overflow_o[0]}, 32'd1);
    check("ovf_flag1", {31'd0, overflow_o[1]}, 32'd0);
    step(2'b00, 1'b1, 1'b1);
    check("ovf_clear_flag0", {31'd0, overflow_o[0]}, 32'd0);
    check("ovf_clear_cnt0", counters_o[0], 32'd0);

    // Reset mid-period discards the partial count.
    step(2'b01, 1'b1, 1'b1);
    check("pre_rst_cnt0", counters_o[0], 32'd1);
    for (int i = 0; i < 7; i++) step(2'b11, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_cnt0", counters_o[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1);
    check("midrst_after_cnt0", counters_o[0], 32'd2);
    check("midrst_after_cnt1", counters_o[1], 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
